gmii_rx_framer: RTL and testbench

- Receive-side frame engine placed directly after the rgmii DDR decoder, on its byte-wide GMII-style output at 125 MHz.
- Strips the preamble and SFD, optionally checks and strips the FCS, and enforces frame length limits.
- Emits each frame as a byte stream with end-of-frame and error flags, plus per-frame status pulses.
- Parametrised successor to the raw RX_DATA/RX_DV byte pass-through: it adds framing, CRC and error reporting, and offers no backpressure because it runs at line rate.

---
 rtl/gmii_pkg.sv | 27 ++
 rtl/crc32_byte.sv | 22 ++
 rtl/gmii_rx_framer.sv | 227 ++++++++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_pkg.sv
// Shared constants and types for the GMII receive/transmit framers.
package gmii_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int unsigned PREAMBLE_MAX  = 7;

    // Bit positions inside FRAME_ERR.
    localparam int unsigned ERR_PHY = 0;
    localparam int unsigned ERR_FCS = 1;
    localparam int unsigned ERR_LEN = 2;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_e;

    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte step of the reflected (LSB-first) Ethernet CRC-32.
module crc32_byte
    import gmii_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    localparam logic [31:0] PolyRefl = bit_reverse32(CRC32_POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_i ^ {24'd0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ PolyRefl) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks and optionally strips FCS,
// enforces length limits and reports per-frame status at line rate.
module gmii_rx_framer
    import gmii_pkg::*;
#(
    parameter bit          STRIP_FCS = 1'b1,
    parameter bit          CHECK_FCS = 1'b1,
    parameter int unsigned MIN_LEN   = 64,
    parameter int unsigned MAX_LEN   = 1518,
    parameter int unsigned LEN_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       GMII_RXD,
    input  logic             GMII_RX_DV,
    input  logic             GMII_RX_ER,
    output logic [7:0]       M_TDATA,
    output logic             M_TVALID,
    output logic             M_TLAST,
    output logic             M_TUSER,
    output logic             FRAME_OK,
    output logic             FRAME_BAD,
    output logic [LEN_W-1:0] FRAME_LEN,
    output logic [2:0]       FRAME_ERR
);

    localparam int unsigned D = STRIP_FCS ? 5 : 1;

    localparam logic [LEN_W-1:0] MinLen = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DLen   = LEN_W'(D);
    localparam logic [LEN_W-1:0] CntMax = '1;

    logic [7:0]       rxd_q;
    logic             dv_q, er_q;
    rx_state_e        state_q, state_d;
    logic [2:0]       pre_cnt_q, pre_cnt_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [31:0]      crc_q, crc_d, crc_next;
    logic             phy_q, phy_d;
    logic [7:0]       line_q [D];
    logic [7:0]       line_d [D];

    logic [7:0]       tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic             ok_q, ok_d, bad_q, bad_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [2:0]       err_q, err_d, err_v;

    crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (rxd_q),
        .crc_o  (crc_next)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rxd_q <= '0;
            dv_q  <= 1'b0;
            er_q  <= 1'b0;
        end else begin
            rxd_q <= GMII_RXD;
            dv_q  <= GMII_RX_DV;
            er_q  <= GMII_RX_ER;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dv_q) begin
                    if (rxd_q == PREAMBLE_BYTE) begin
                        state_d = PREAMBLE;
                    end else if (rxd_q == SFD_BYTE) begin
                        state_d = DATA;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!dv_q) begin
                    state_d = IDLE;
                end else if (rxd_q == SFD_BYTE) begin
                    state_d = DATA;
                end else if (rxd_q != PREAMBLE_BYTE || pre_cnt_q >= 3'(PREAMBLE_MAX)) begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (!dv_q) begin
                    state_d = IDLE;
                end else if (count_q == MaxLen) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (!dv_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        count_d   = count_q;
        crc_d     = crc_q;
        phy_d     = phy_q;
        line_d    = line_q;
        tdata_d   = '0;
        tvalid_d  = 1'b0;
        tlast_d   = 1'b0;
        tuser_d   = 1'b0;
        ok_d      = 1'b0;
        bad_d     = 1'b0;
        len_d     = '0;
        err_d     = '0;
        err_v     = '0;
        case (state_q)
            IDLE: begin
                pre_cnt_d = 3'd1;
                count_d   = '0;
                crc_d     = CRC32_INIT;
                phy_d     = 1'b0;
            end
            PREAMBLE: begin
                pre_cnt_d = pre_cnt_q + 3'd1;
            end
            DATA: begin
                if (dv_q) begin
                    count_d   = (count_q == CntMax) ? count_q : count_q + 1'b1;
                    crc_d     = crc_next;
                    phy_d     = phy_q | er_q;
                    line_d[0] = rxd_q;
                    for (int i = 1; i < D; i++) begin
                        line_d[i] = line_q[i-1];
                    end
                    if (count_q >= DLen) begin
                        tvalid_d = 1'b1;
                        tdata_d  = line_q[D-1];
                    end
                    // Oversize: the byte taking the count past MAX_LEN closes the frame.
                    if (count_q == MaxLen) begin
                        err_v[ERR_LEN] = 1'b1;
                        err_v[ERR_FCS] = CHECK_FCS && (crc_next != CRC32_RESIDUE);
                        err_v[ERR_PHY] = phy_q | er_q;
                        tlast_d = 1'b1;
                        tuser_d = 1'b1;
                        bad_d   = 1'b1;
                        len_d   = count_d;
                        err_d   = err_v;
                    end
                end else begin
                    err_v[ERR_LEN] = (count_q < MinLen) || (count_q > MaxLen);
                    err_v[ERR_FCS] = CHECK_FCS && (crc_q != CRC32_RESIDUE);
                    err_v[ERR_PHY] = phy_q;
                    if (count_q >= DLen) begin
                        tvalid_d = 1'b1;
                        tdata_d  = line_q[D-1];
                        tlast_d  = 1'b1;
                        tuser_d  = |err_v;
                    end
                    ok_d  = ~|err_v;
                    bad_d = |err_v;
                    len_d = count_q;
                    err_d = err_v;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pre_cnt_q <= '0;
            count_q   <= '0;
            crc_q     <= CRC32_INIT;
            phy_q     <= 1'b0;
            for (int i = 0; i < D; i++) begin
                line_q[i] <= '0;
            end
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            ok_q     <= 1'b0;
            bad_q    <= 1'b0;
            len_q    <= '0;
            err_q    <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            count_q   <= count_d;
            crc_q     <= crc_d;
            phy_q     <= phy_d;
            line_q    <= line_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            ok_q      <= ok_d;
            bad_q     <= bad_d;
            len_q     <= len_d;
            err_q     <= err_d;
        end
    end

    assign M_TDATA   = tdata_q;
    assign M_TVALID  = tvalid_q;
    assign M_TLAST   = tlast_q;
    assign M_TUSER   = tuser_q;
    assign FRAME_OK  = ok_q;
    assign FRAME_BAD = bad_q;
    assign FRAME_LEN = len_q;
    assign FRAME_ERR = err_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Randomised self-checking bench for gmii_rx_framer against a frame-level reference model.
module tb_gmii_rx_framer;

    localparam int MinLen = 64;
    localparam int MaxLen = 1518;
    localparam int Dly    = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rxd = '0;
    logic        dv  = 1'b0;
    logic        er  = 1'b0;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tuser, frame_ok, frame_bad;
    logic [15:0] frame_len;
    logic [2:0]  frame_err;

    gmii_rx_framer #(
        .STRIP_FCS (1'b1),
        .CHECK_FCS (1'b1),
        .MIN_LEN   (MinLen),
        .MAX_LEN   (MaxLen),
        .LEN_W     (16)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .GMII_RXD   (rxd),
        .GMII_RX_DV (dv),
        .GMII_RX_ER (er),
        .M_TDATA    (m_tdata),
        .M_TVALID   (m_tvalid),
        .M_TLAST    (m_tlast),
        .M_TUSER    (m_tuser),
        .FRAME_OK   (frame_ok),
        .FRAME_BAD  (frame_bad),
        .FRAME_LEN  (frame_len),
        .FRAME_ERR  (frame_err)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         cyc;
    } beat_t;

    typedef struct {
        logic        ok;
        logic        bad;
        logic [15:0] len;
        logic [2:0]  err;
        int          cyc;
    } stat_t;

    beat_t      obs_b[$];
    beat_t      exp_b[$];
    stat_t      obs_s[$];
    stat_t      exp_s[$];
    logic [7:0] frm_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int t_first, t_end;

    always @(negedge clk) begin
        if (m_tvalid) obs_b.push_back('{m_tdata, m_tlast, m_tuser, cyc});
        if (frame_ok || frame_bad) obs_s.push_back('{frame_ok, frame_bad, frame_len, frame_err, cyc});
    end

    initial begin
        #720000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc32_of(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, frm_q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic build_frame(input int n_data, input bit ramp, input bit corrupt);
        logic [31:0] fcs;
        frm_q.delete();
        for (int i = 0; i < n_data; i++) frm_q.push_back(ramp ? 8'(i) : 8'($urandom));
        fcs = ~crc32_of(n_data);
        for (int i = 0; i < 4; i++) frm_q.push_back(fcs[8*i +: 8]);
        if (corrupt) frm_q[frm_q.size()-1] = frm_q[frm_q.size()-1] ^ 8'h01;
    endtask

    // Expected output of a frame whose preamble is accepted.
    task automatic model_frame(input int er_idx);
        int          n, len, last_idx;
        bit          trunc, phy, fcs_bad, len_bad;
        logic [31:0] fcs_rx;
        logic [2:0]  err;
        n     = frm_q.size();
        trunc = n > MaxLen;
        len   = trunc ? MaxLen + 1 : n;
        phy   = (er_idx >= 0) && (er_idx < len);
        if (len >= 4) begin
            fcs_rx  = {frm_q[len-1], frm_q[len-2], frm_q[len-3], frm_q[len-4]};
            fcs_bad = fcs_rx != ~crc32_of(len - 4);
        end else begin
            fcs_bad = 1'b1;
        end
        len_bad  = (len < MinLen) || (len > MaxLen);
        err      = {len_bad, fcs_bad, phy};
        last_idx = trunc ? len - 1 - Dly : len - Dly;
        for (int i = 0; i <= last_idx; i++)
            exp_b.push_back('{frm_q[i], i == last_idx, (i == last_idx) ? |err : 1'b0, 0});
        exp_s.push_back('{~|err, |err, 16'(len), err, 0});
    endtask

    task automatic drive(input logic [7:0] b, input logic v, input logic e);
        @(posedge clk);
        #1;
        rxd = b;
        dv  = v;
        er  = e;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int pre_len, input int er_idx, input int gap);
        for (int i = 0; i < pre_len; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < frm_q.size(); i++) begin
            drive(frm_q[i], 1'b1, i == er_idx);
            if (i == 0) t_first = cyc;
        end
        for (int g = 0; g < gap; g++) begin
            drive(8'h00, 1'b0, 1'b0);
            if (g == 0) t_end = cyc;
        end
    endtask

    task automatic send_bad_pre(input int kind, input int gap);
        case (kind)
            0: for (int i = 0; i < 8; i++) drive(8'h55, 1'b1, 1'b0);
            1: drive(8'h3C, 1'b1, 1'b0);
            default: begin
                drive(8'h55, 1'b1, 1'b0);
                drive(8'h55, 1'b1, 1'b0);
                drive(8'h12, 1'b1, 1'b0);
            end
        endcase
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) drive(8'($urandom), 1'b1, 1'b0);
        idle(gap);
    endtask

    task automatic compare_all(input string tag);
        int nb, ns;
        check({tag, "_nbeats"}, obs_b.size(), exp_b.size());
        nb = (obs_b.size() < exp_b.size()) ? obs_b.size() : exp_b.size();
        for (int i = 0; i < nb; i++)
            check({tag, "_beat"}, {obs_b[i].data, obs_b[i].last, obs_b[i].user},
                  {exp_b[i].data, exp_b[i].last, exp_b[i].user});
        check({tag, "_nstat"}, obs_s.size(), exp_s.size());
        ns = (obs_s.size() < exp_s.size()) ? obs_s.size() : exp_s.size();
        for (int i = 0; i < ns; i++)
            check({tag, "_stat"}, {obs_s[i].ok, obs_s[i].bad, obs_s[i].len, obs_s[i].err},
                  {exp_s[i].ok, exp_s[i].bad, exp_s[i].len, exp_s[i].err});
        obs_b.delete();
        exp_b.delete();
        obs_s.delete();
        exp_s.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {m_tdata, m_tvalid, m_tlast, m_tuser, frame_ok, frame_bad, frame_len, frame_err},
              32'd0);
    endtask

    initial begin
        int er_idx, pre_len, n_data, kind;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset_outputs");
        @(posedge clk);
        #1 rst = 1'b0;
        idle(4);

        // Minimum-size good frame with ramp payload, plus latency checks.
        build_frame(60, 1'b1, 1'b0);
        model_frame(-1);
        send_frame(7, -1, 10);
        check("first_beat_latency", (obs_b.size() > 0) ? obs_b[0].cyc - t_first : -1, 7);
        check("tlast_latency", (obs_b.size() > 0) ? obs_b[obs_b.size()-1].cyc - t_end : -1, 2);
        check("status_latency", (obs_s.size() > 0) ? obs_s[0].cyc - t_end : -1, 2);
        compare_all("good64");

        build_frame(60, 1'b1, 1'b1);
        model_frame(-1);
        send_frame(7, -1, 10);
        compare_all("bad_fcs");

        build_frame(36, 1'b0, 1'b0);
        model_frame(-1);
        send_frame(7, -1, 10);
        compare_all("runt40");

        // Oversize frame, then a normal frame after a one-cycle gap.
        build_frame(1596, 1'b0, 1'b0);
        model_frame(-1);
        send_frame(7, -1, 1);
        build_frame(70, 1'b0, 1'b0);
        model_frame(-1);
        send_frame(7, -1, 10);
        compare_all("oversize");

        send_bad_pre(2, 1);
        build_frame(60, 1'b0, 1'b0);
        model_frame(-1);
        send_frame(7, -1, 10);
        compare_all("bad_preamble");

        build_frame(60, 1'b0, 1'b0);
        model_frame(20);
        send_frame(7, 20, 10);
        compare_all("rx_er");

        // Reset after 30 post-SFD bytes: beats already in flight are seen, no TLAST, no status.
        build_frame(60, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) drive(frm_q[i], 1'b1, 1'b0);
        for (int i = 0; i <= 30 - 7; i++) exp_b.push_back('{frm_q[i], 1'b0, 1'b0, 0});
        @(posedge clk);
        #1;
        rst = 1'b1;
        dv  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("midframe_reset_outputs");
        @(posedge clk);
        #1 rst = 1'b0;
        idle(12);
        compare_all("midframe_reset");
        build_frame(64, 1'b0, 1'b0);
        model_frame(-1);
        send_frame(7, -1, 10);
        compare_all("after_reset");

        for (int f = 0; f < 48; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                kind = $urandom_range(0, 2);
                send_bad_pre(kind, $urandom_range(1, 3));
            end else begin
                pre_len = $urandom_range(0, 7);
                n_data  = ($urandom_range(0, 9) == 0) ? $urandom_range(1500, 1560)
                                                      : $urandom_range(40, 200);
                build_frame(n_data, 1'b0, $urandom_range(0, 3) == 0);
                er_idx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n_data - 1) : -1;
                model_frame(er_idx);
                send_frame(pre_len, er_idx, $urandom_range(1, 3));
            end
            if (f % 8 == 7) begin
                idle(12);
                compare_all("random");
            end
        end
        idle(12);
        compare_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
